uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per bit (100 MHz / 115200 baud).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flop count on rx_serial.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx_serial  input  1  asynchronous serial line, idle high.
REQ-006 rx_data  output  8  last received byte, held until next valid byte.
REQ-007 rx_valid  output  1  one-cycle pulse, rx_data newly valid.
REQ-008 rx_busy  output  1  high while a frame is in progress (state != IDLE).
REQ-009 rx_frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 rx_parity_err  output  1  one-cycle pulse, parity mismatch (see Configuration).

Function
REQ-011 Frame: 1 start bit (0), 8 data bits LSB first, optional parity, 1 stop bit (1).
REQ-012 rx_serial SHALL pass through SYNC_STAGES flops, preset to 1, before any use.
REQ-013 States and encodings: IDLE 3'b000, START 3'b001, DATA 3'b010, STOP 3'b011, PARITY 3'b100.
REQ-014 IDLE -> START on synchronized falling level (line sampled 0); baud counter cleared.
REQ-015 START: at count CLKS_PER_BIT/2-1 re-sample; 0 -> DATA with counter cleared; 1 -> IDLE (glitch rejected, no pulse).
REQ-016 DATA: sample each bit when counter reaches CLKS_PER_BIT-1 (mid-bit); shift into bit[index]; after bit 7 -> STOP (or PARITY).
REQ-017 STOP: sample at mid-bit; 1 -> update rx_data, pulse rx_valid; 0 -> pulse rx_frame_err, rx_data unchanged; then IDLE.
REQ-018 rx_valid/rx_frame_err asserted exactly one clk cycle, registered, on cycle after stop sample.
REQ-019 Return to IDLE occurs at stop-bit mid-point, so a start bit immediately following the stop bit is detected (back-to-back frames).
REQ-020 Line held low after frame error: stays in IDLE until line returns high, then low again (no repeated frames on break).
REQ-021 Baud counter width = $clog2(CLKS_PER_BIT); bit index 3 bits; no wrap beyond CLKS_PER_BIT-1.
REQ-022 rx_serial transitions during a bit SHALL NOT affect sampling except at the sample point.

Reset
REQ-023 reset low: state IDLE, counters 0, rx_data 8'h00, rx_valid 0, rx_busy 0, rx_frame_err 0, rx_parity_err 0, synchronizer flops 1.
REQ-024 reset asserted mid-frame aborts frame, no pulse; after release, receiver waits for new start bit.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: even parity bit expected after bit 7; PARITY state samples it; mismatch -> rx_parity_err pulse with rx_valid suppressed; stop check still performed.
REQ-026 UART_RX_PARITY_EN undefined: PARITY state absent, DATA -> STOP directly, rx_parity_err tied 0.

Structure
REQ-027 Package uart_pkg SHALL hold state typedef/encodings, DEFAULT_CLKS_PER_BIT = 868, frame constants (DATA_BITS = 8).
REQ-028 Synchronizer SHALL be sub-module uart_rx_sync (parameter SYNC_STAGES, reset value 1).

Verification
REQ-029 Drive 0x55 at 8680 ns/bit -> one rx_valid pulse, rx_data 8'h55, rx_busy low after.
REQ-030 Three $random bytes, back-to-back frames with zero idle (0xAA then 0xBB) -> two rx_valid pulses, data 8'hAA then 8'hBB.
REQ-031 1000 ns low glitch on idle line -> FSM returns IDLE from START, no rx_valid, no rx_frame_err.
REQ-032 Frame 0x3C with stop bit driven 0 -> rx_frame_err pulse, rx_valid 0, rx_data keeps previous value.
REQ-033 reset low during DATA bit 4 of 0xF0 -> all outputs reset values, next frame 0x81 received correctly.
REQ-034 With UART_RX_PARITY_EN: 0x07 with parity bit 0 (wrong) -> rx_parity_err pulse, no rx_valid; with parity 1 -> rx_valid, 8'h07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encodings and frame constants.
// Parity support in uart_rx is enabled by defining UART_RX_PARITY_EN.
package uart_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 868;
   localparam int DATA_BITS            = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'b000,
      START  = 3'b001,
      DATA   = 3'b010,
      STOP   = 3'b011,
      PARITY = 3'b100
   } uart_state_t;

   // Even parity: the parity bit makes the total count of ones even.
   function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; flops preset to the
// idle (high) level so that reset never looks like a start bit.
module uart_rx_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '1;
      end else begin
         sync_q[0] <= d;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and frame-error detection.
// Define UART_RX_PARITY_EN to expect an even parity bit after the data bits.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx_serial,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_busy,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

   uart_state_t          state;
   logic [CNT_W-1:0]     baud_cnt;
   logic [2:0]           bit_idx;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 rx_sync;
   logic                 wait_high;
`ifdef UART_RX_PARITY_EN
   logic                 par_bit;
   logic                 par_bad;

   assign par_bad = (par_bit != even_parity(shift_reg));
`else
   assign rx_parity_err = 1'b0;
`endif

   uart_rx_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx_serial),
      .q     (rx_sync)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         baud_cnt     <= '0;
         bit_idx      <= '0;
         shift_reg    <= '0;
         wait_high    <= 1'b0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_busy      <= 1'b0;
         rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit       <= 1'b0;
         rx_parity_err <= 1'b0;
`endif
      end else begin
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         rx_parity_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               bit_idx  <= '0;
               // After a frame error the line must go idle before a new start counts.
               if (wait_high) begin
                  if (rx_sync) wait_high <= 1'b0;
               end else if (!rx_sync) begin
                  state   <= START;
                  rx_busy <= 1'b1;
               end
            end
            START: begin
               if (baud_cnt == CNT_MID) begin
                  baud_cnt <= '0;
                  if (!rx_sync) begin
                     state <= DATA;
                  end else begin
                     state   <= IDLE;
                     rx_busy <= 1'b0;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (baud_cnt == CNT_LAST) begin
                  baud_cnt           <= '0;
                  shift_reg[bit_idx] <= rx_sync;
                  if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (baud_cnt == CNT_LAST) begin
                  baud_cnt <= '0;
                  par_bit  <= rx_sync;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
`endif
            STOP: begin
               // Leave at mid-stop so a start bit right behind it is caught.
               if (baud_cnt == CNT_LAST) begin
                  baud_cnt <= '0;
                  state    <= IDLE;
                  rx_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                  rx_parity_err <= par_bad;
                  if (rx_sync && !par_bad) begin
`else
                  if (rx_sync) begin
`endif
                     rx_data  <= shift_reg;
                     rx_valid <= 1'b1;
                  end
                  if (!rx_sync) begin
                     rx_frame_err <= 1'b1;
                     wait_high    <= 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               rx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: clean frames, back-to-back frames, glitch, frame
// error with held break, mid-frame reset and (with UART_RX_PARITY_EN) parity.
module tb_uart_rx;

   localparam int CPB = 64;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       rx_serial;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       rx_frame_err;
   logic       rx_parity_err;

   int n_cmp = 0;
   int n_bad = 0;
   int vcnt = 0;
   int fcnt = 0;
   int pcnt = 0;
   logic [7:0] vq[$];

   uart_rx #(
      .CLKS_PER_BIT (CPB),
      .SYNC_STAGES  (2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .rx_serial     (rx_serial),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_busy       (rx_busy),
      .rx_frame_err  (rx_frame_err),
      .rx_parity_err (rx_parity_err)
   );

   always #5 clk = ~clk;

   // Pulse counters: a pulse longer than one cycle shows up as an extra count.
   always @(negedge clk) begin
      if (rx_valid) begin
         vcnt++;
         vq.push_back(rx_data);
      end
      if (rx_frame_err) fcnt++;
      if (rx_parity_err) pcnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic bit_time(input logic v);
      rx_serial = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_raw(input logic [7:0] b, input logic stop_v,
                           input logic has_par, input logic par_v);
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(b[i]);
      if (has_par) bit_time(par_v);
      bit_time(stop_v);
   endtask

   task automatic send_frame(input logic [7:0] b);
      send_raw(b, 1'b1, PAR_EN, ^b);
   endtask

   initial begin
      logic [7:0] rb;
      int v0;
      int f0;

      reset     = 1'b0;
      rx_serial = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_data", rx_data, 8'h00);
      chk("rst_valid", rx_valid, 1'b0);
      chk("rst_busy", rx_busy, 1'b0);
      chk("rst_ferr", rx_frame_err, 1'b0);
      chk("rst_perr", rx_parity_err, 1'b0);
      reset = 1'b1;
      repeat (10) @(negedge clk);

      // Single clean frame
      send_frame(8'h55);
      repeat (4) @(negedge clk);
      chk("x55_count", vcnt, 1);
      chk("x55_data", rx_data, 8'h55);
      chk("x55_busy", rx_busy, 1'b0);
      chk("x55_ferr", fcnt, 0);

      // Random bytes with idle gaps
      for (int k = 0; k < 3; k++) begin
         rb = 8'($urandom_range(0, 255));
         v0 = vcnt;
         send_frame(rb);
         repeat (CPB) @(negedge clk);
         chk("rand_count", vcnt - v0, 1);
         chk("rand_data", rx_data, rb);
      end

      // Back-to-back, no idle between stop and next start
      vq.delete();
      send_frame(8'hAA);
      send_frame(8'hBB);
      repeat (4) @(negedge clk);
      chk("b2b_count", vq.size(), 2);
      if (vq.size() == 2) begin
         chk("b2b_first", vq[0], 8'hAA);
         chk("b2b_second", vq[1], 8'hBB);
      end
      chk("b2b_data", rx_data, 8'hBB);

      // Short low glitch on idle line
      v0 = vcnt;
      f0 = fcnt;
      rx_serial = 1'b0;
      repeat (10) @(negedge clk);
      chk("glitch_busy_hi", rx_busy, 1'b1);
      repeat (10) @(negedge clk);
      rx_serial = 1'b1;
      repeat (CPB) @(negedge clk);
      chk("glitch_busy_lo", rx_busy, 1'b0);
      chk("glitch_valid", vcnt - v0, 0);
      chk("glitch_ferr", fcnt - f0, 0);

      // Stop bit low, then line held low (break)
      v0 = vcnt;
      send_raw(8'h3C, 1'b0, PAR_EN, ^8'h3C);
      repeat (2 * CPB) @(negedge clk);
      chk("ferr_count", fcnt - f0, 1);
      chk("ferr_valid", vcnt - v0, 0);
      chk("ferr_data", rx_data, 8'hBB);
      chk("break_busy", rx_busy, 1'b0);
      rx_serial = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      chk("break_ferr", fcnt - f0, 1);

      // Reset in the middle of data bit 4 of 0xF0
      v0 = vcnt;
      bit_time(1'b0);
      for (int i = 0; i < 4; i++) bit_time(1'b0);
      rx_serial = 1'b1;
      repeat (CPB / 2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mid_rst_data", rx_data, 8'h00);
      chk("mid_rst_busy", rx_busy, 1'b0);
      chk("mid_rst_valid", rx_valid, 1'b0);
      chk("mid_rst_ferr", rx_frame_err, 1'b0);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      repeat (4 * CPB) @(negedge clk);
      chk("post_rst_busy", rx_busy, 1'b0);
      chk("post_rst_nopulse", vcnt - v0, 0);
      send_frame(8'h81);
      repeat (4) @(negedge clk);
      chk("x81_count", vcnt - v0, 1);
      chk("x81_data", rx_data, 8'h81);

`ifdef UART_RX_PARITY_EN
      v0 = vcnt;
      send_raw(8'h07, 1'b1, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      chk("par_bad_perr", pcnt, 1);
      chk("par_bad_valid", vcnt - v0, 0);
      chk("par_bad_data", rx_data, 8'h81);
      send_raw(8'h07, 1'b1, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      chk("par_ok_valid", vcnt - v0, 1);
      chk("par_ok_data", rx_data, 8'h07);
`endif
      chk("perr_total", pcnt, PAR_EN ? 1 : 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
